// File: rtl/demux1to2_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux1to2_stream: 1-to-2 valid/ready packet demux, 2-entry buffer per output. |
// | Optional macro DEMUX_STATS_EN adds per-destination packet counters. Rev 1.0 |
// +--------------------------------------------------------------------------+
module demux1to2_stream #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_sel,
   output logic              out0_valid,
   input  logic              out0_ready,
   output logic [DATA_W-1:0] out0_data,
   output logic              out0_last,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [DATA_W-1:0] out1_data,
   output logic              out1_last,
   output logic              busy
`ifdef DEMUX_STATS_EN
   ,
   output logic [15:0]       pkt0_count,
   output logic [15:0]       pkt1_count
`endif
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_lock0 = 2'd1;
   localparam logic [1:0] c_lock1 = 2'd2;

   logic [1:0]      state_q, state_d;
   logic            dest_w;
   logic            push_w;
   logic [1:0]      full_w;
   logic [1:0]      valid_w;
   logic [1:0]      pop_w;
   logic [1:0]      push_buf_w;
   logic [1:0]      out_ready_w;
   logic [DATA_W:0] head_w [2];

   assign out_ready_w = {out1_ready, out0_ready};
   assign push_w      = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= c_idle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (push_w) begin
         case (state_q)
            c_idle: begin
               if (!in_last) state_d = in_sel ? c_lock1 : c_lock0;
            end
            c_lock0, c_lock1: begin
               if (in_last) state_d = c_idle;
            end
            default: state_d = c_idle;
         endcase
      end
   end

   // Destination follows in_sel only between packets; ready never looks at in_valid.
   always_comb begin
      busy     = (state_q != c_idle);
      dest_w   = (state_q == c_idle) ? in_sel : (state_q == c_lock1);
      in_ready = !full_w[dest_w];
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      logic [DATA_W:0] mem_q [2];
      logic            wr_ptr_q;
      logic            rd_ptr_q;
      logic [1:0]      cnt_q;

      assign push_buf_w[gi] = push_w && (dest_w == 1'(gi));
      assign valid_w[gi]    = (cnt_q != 2'd0);
      assign full_w[gi]     = (cnt_q == 2'd2);
      assign pop_w[gi]      = valid_w[gi] && out_ready_w[gi];
      assign head_w[gi]     = mem_q[rd_ptr_q];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
         end else begin
            if (push_buf_w[gi]) begin
               mem_q[wr_ptr_q] <= {in_last, in_data};
               wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_w[gi]) rd_ptr_q <= ~rd_ptr_q;
            case ({push_buf_w[gi], pop_w[gi]})
               2'b10:   cnt_q <= cnt_q + 2'd1;
               2'b01:   cnt_q <= cnt_q - 2'd1;
               default: cnt_q <= cnt_q;
            endcase
         end
      end
   end

   assign out0_valid              = valid_w[0];
   assign {out0_last, out0_data}  = head_w[0];
   assign out1_valid              = valid_w[1];
   assign {out1_last, out1_data}  = head_w[1];

`ifdef DEMUX_STATS_EN
   logic [15:0] pkt0_q;
   logic [15:0] pkt1_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt0_q <= 16'd0;
         pkt1_q <= 16'd0;
      end else if (push_w && in_last) begin
         if (!dest_w && pkt0_q != 16'hFFFF) pkt0_q <= pkt0_q + 16'd1;
         if (dest_w && pkt1_q != 16'hFFFF)  pkt1_q <= pkt1_q + 16'd1;
      end
   end

   assign pkt0_count = pkt0_q;
   assign pkt1_count = pkt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux1to2_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_demux1to2_stream: directed bench with per-output expected-beat queues.  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_demux1to2_stream;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_ready, in_last, in_sel;
   logic [DATA_W-1:0] in_data;
   logic              out0_valid, out0_ready, out0_last;
   logic [DATA_W-1:0] out0_data;
   logic              out1_valid, out1_ready, out1_last;
   logic [DATA_W-1:0] out1_data;
   logic              busy;
`ifdef DEMUX_STATS_EN
   logic [15:0]       pkt0_count, pkt1_count;
`endif

   int total = 0;
   int bad   = 0;
   logic [DATA_W:0] exp0 [$];
   logic [DATA_W:0] exp1 [$];
   logic            lock_active = 1'b0;
   logic            lock_dest   = 1'b0;

   demux1to2_stream #(.DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_sel     (in_sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out0_last  (out0_last),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .out1_last  (out1_last),
      .busy       (busy)
`ifdef DEMUX_STATS_EN
      ,
      .pkt0_count (pkt0_count),
      .pkt1_count (pkt1_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected destination comes from the bench's own packet-lock model.
   task automatic send(input logic [7:0] d, input logic s, input logic l);
      logic ok;
      logic dst;
      ok       = 1'b0;
      in_data  = d;
      in_sel   = s;
      in_last  = l;
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) begin
            dst = lock_active ? lock_dest : s;
            if (dst) exp1.push_back({l, d});
            else     exp0.push_back({l, d});
            if (l) lock_active = 1'b0;
            else if (!lock_active) begin
               lock_active = 1'b1;
               lock_dest   = s;
            end
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (out0_valid && out0_ready) begin
            if (exp0.size() == 0) chk("out0_unexpected", 32'd1, 32'd0);
            else chk("out0_beat", 32'({out0_last, out0_data}), 32'(exp0.pop_front()));
         end
         if (out1_valid && out1_ready) begin
            if (exp1.size() == 0) chk("out1_unexpected", 32'd1, 32'd0);
            else chk("out1_beat", 32'({out1_last, out1_data}), 32'(exp1.pop_front()));
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_sel = 1'b0;
      out0_ready = 1'b1; out1_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_out0_valid", 32'(out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(out1_valid), 32'd0);
      chk("rst_out0_data", 32'(out0_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      in_sel = 1'b0; #1 chk("rst_ready_sel0", 32'(in_ready), 32'd1);
      in_sel = 1'b1; #1 chk("rst_ready_sel1", 32'(in_ready), 32'd1);
`ifdef DEMUX_STATS_EN
      chk("rst_pkt0", 32'(pkt0_count), 32'd0);
`endif

      send(8'hA5, 1'b0, 1'b1);
      chk("single0_valid", 32'(out0_valid), 32'd1);
      chk("single0_head", 32'({out0_last, out0_data}), 32'h1A5);
      chk("single0_other", 32'(out1_valid), 32'd0);
      send(8'h3C, 1'b1, 1'b1);
      chk("single1_head", 32'({out1_valid, out1_last, out1_data}), 32'h33C);
      chk("single1_other", 32'(out0_valid), 32'd0);

      send(8'h11, 1'b1, 1'b0);
      chk("lock_busy1", 32'(busy), 32'd1);
      send(8'h22, 1'b0, 1'b0);
      chk("lock_busy2", 32'(busy), 32'd1);
      chk("lock_out0_idle", 32'(out0_valid), 32'd0);
      send(8'h33, 1'b0, 1'b1);
      chk("lock_busy_end", 32'(busy), 32'd0);
      chk("lock_tail", 32'({out1_valid, out1_last, out1_data}), 32'h333);
      chk("lock_out0_idle2", 32'(out0_valid), 32'd0);

      out0_ready = 1'b0;
      send(8'h01, 1'b0, 1'b1);
      send(8'h02, 1'b0, 1'b1);
      in_sel = 1'b0; #1 chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_head", 32'(out0_data), 32'h01);
      send(8'h77, 1'b1, 1'b1);
      chk("indep_out1", 32'({out1_valid, out1_data}), 32'h177);
      chk("indep_out0_stalled", 32'(out0_valid), 32'd1);
      out0_ready = 1'b1; in_sel = 1'b0; in_valid = 1'b1; in_data = 8'h03; in_last = 1'b1;
      #1 chk("no_passthrough", 32'(in_ready), 32'd0);
      send(8'h03, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;

      out0_ready = 1'b0;
      send(8'h44, 1'b0, 1'b0);
      chk("midrst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp0.delete();
      lock_active = 1'b0;
      chk("midrst_out0_valid", 32'(out0_valid), 32'd0);
      chk("midrst_out0_data", 32'(out0_data), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
`ifdef DEMUX_STATS_EN
      chk("midrst_pkt0", 32'(pkt0_count), 32'd0);
      chk("midrst_pkt1", 32'(pkt1_count), 32'd0);
`endif
      out0_ready = 1'b1;
      send(8'h55, 1'b1, 1'b1);
      chk("midrst_route1", 32'({out1_valid, out1_data}), 32'h155);
      chk("midrst_route_other", 32'(out0_valid), 32'd0);
`ifdef DEMUX_STATS_EN
      chk("stats_pkt1", 32'(pkt1_count), 32'd1);
      chk("stats_pkt0", 32'(pkt0_count), 32'd0);
`endif

      for (int k = 0; k < 20 && (exp0.size() != 0 || exp1.size() != 0); k++) @(negedge clk);
      chk("drain_out0", 32'(exp0.size()), 32'd0);
      chk("drain_out1", 32'(exp1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
